uart_alu_sequencer: RTL and testbench

- Parametrised command sequencer between a byte-wide UART and a DATA_W-bit combinational ALU.
- Assembles multi-byte frames of the form `A, opcode, B` from the UART receiver, decodes the ASCII opcode, and drives the ALU operands.
- Captures the ALU result and streams it back through the UART transmitter with a proper ready/start handshake.
- Adds inter-byte timeout, invalid-opcode error reply and overrun flagging.

---
 rtl/uart_alu_sequencer.sv | 156 +++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between a byte UART and a DATA_W-bit combinational ALU:
// collects "A, opcode, B" frames, drives the ALU, and streams the result back LSB byte first.
module uart_alu_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ERR_BYTE    = 8'h3F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NB - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {RX_A, RX_OP, RX_B, CALC, TX_SEND, TX_WAIT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [TMO_W-1:0]    tmo;
  logic [DATA_W-1:0]   res;
  logic [OP_W-1:0]     op_dec;
  logic                op_valid;
  logic                tmo_run;

  // ASCII opcode to ALU function code
  always_comb begin
    op_valid = 1'b1;
    op_dec   = '0;
    case (rx_data)
      8'h2B:   op_dec = OP_W'(6'b100000);
      8'h2D:   op_dec = OP_W'(6'b100010);
      8'h26:   op_dec = OP_W'(6'b100100);
      8'h7C:   op_dec = OP_W'(6'b100101);
      8'h5E:   op_dec = OP_W'(6'b100110);
      8'h7E:   op_dec = OP_W'(6'b100111);
      8'h3E:   op_dec = OP_W'(6'b000011);
      8'h7D:   op_dec = OP_W'(6'b000010);
      default: op_valid = 1'b0;
    endcase
  end

  assign tmo_run = (state == RX_A && cnt != '0) || state == RX_OP || state == RX_B;
  assign busy    = (state != RX_A) || (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_A;
      cnt       <= '0;
      tmo       <= '0;
      res       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Inter-byte timer; a byte arriving on the expiry cycle takes priority
      if (tmo_run) begin
        if (rx_done) begin
          tmo <= '0;
        end else if (tmo == TMO_MAX) begin
          frame_err <= 1'b1;
          state     <= RX_A;
          cnt       <= '0;
          tmo       <= '0;
        end else begin
          tmo <= tmo + TMO_W'(1);
        end
      end

      if (rx_done && (state == CALC || state == TX_SEND || state == TX_WAIT))
        overrun <= 1'b1;

      case (state)
        RX_A, RX_B: begin
          if (rx_done) begin
            for (int unsigned k = 0; k < NB; k++) begin
              if (CNT_W'(k) == cnt) begin
                if (state == RX_A) alu_a[k*8 +: 8] <= rx_data;
                else               alu_b[k*8 +: 8] <= rx_data;
              end
            end
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= (state == RX_A) ? RX_OP : CALC;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RX_OP: begin
          if (rx_done) begin
            if (op_valid) begin
              alu_op <= op_dec;
              state  <= RX_B;
            end else begin
              // Reuse the transmit path: a one-byte "result" holding the error code
              frame_err <= 1'b1;
              res       <= DATA_W'(ERR_BYTE);
              cnt       <= LAST;
              state     <= TX_SEND;
            end
          end
        end
        CALC: begin
          res   <= alu_result;
          cnt   <= '0;
          state <= TX_SEND;
        end
        TX_SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= res[7:0];
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!tx_ready) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= RX_A;
            end else begin
              res   <= res >> 8;
              cnt   <= cnt + CNT_W'(1);
              state <= TX_SEND;
            end
          end
        end
        default: state <= RX_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: an 8-bit and a 16-bit instance share stimulus,
// a behavioural ALU and UART transmitter; reply bytes are checked against a scoreboard queue.
module tb_uart_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_ready;
  int          sel;
  logic        rx_done8, rx_done16;

  logic        tx_start8, busy8, frame_err8, overrun8;
  logic [7:0]  tx_data8, alu_a8, alu_b8, alu_res8;
  logic [5:0]  alu_op8;
  logic        tx_start16, busy16, frame_err16, overrun16;
  logic [7:0]  tx_data16;
  logic [15:0] alu_a16, alu_b16, alu_res16;
  logic [5:0]  alu_op16;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          tx_cnt   = 0;
  logic [7:0]  exp_q[$];
  bit          tx_auto  = 1'b1;
  int          busy_cnt = 0;
  bit          prev_start = 1'b0;
  logic        obs_busy;

  always #5 clk = ~clk;

  assign rx_done8  = rx_done && (sel == 0);
  assign rx_done16 = rx_done && (sel == 1);
  assign obs_busy  = (sel == 1) ? busy16 : busy8;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [5:0] op, input bit w16);
    logic [15:0] sa;
    logic [15:0] r;
    sa = w16 ? a : {{8{a[7]}}, a[7:0]};
    case (op)
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b000011: r = 16'($signed(sa) >>> b[3:0]);
      6'b000010: r = a >> b[3:0];
      default:   r = 16'h0;
    endcase
    return r;
  endfunction

  assign alu_res8  = 8'(alu_f({8'h00, alu_a8}, {8'h00, alu_b8}, alu_op8, 1'b0));
  assign alu_res16 = alu_f(alu_a16, alu_b16, alu_op16, 1'b1);

  uart_alu_sequencer #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYC(16), .ERR_BYTE(8'h3F)) dut8 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done8), .tx_ready(tx_ready),
    .tx_start(tx_start8), .tx_data(tx_data8), .alu_a(alu_a8), .alu_b(alu_b8),
    .alu_op(alu_op8), .alu_result(alu_res8), .busy(busy8), .frame_err(frame_err8),
    .overrun(overrun8)
  );

  uart_alu_sequencer #(.DATA_W(16), .OP_W(6), .TIMEOUT_CYC(16), .ERR_BYTE(8'h3F)) dut16 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done16), .tx_ready(tx_ready),
    .tx_start(tx_start16), .tx_data(tx_data16), .alu_a(alu_a16), .alu_b(alu_b16),
    .alu_op(alu_op16), .alu_result(alu_res16), .busy(busy16), .frame_err(frame_err16),
    .overrun(overrun16)
  );

  // Reply monitor and transmitter model: checks each tx_start, then drops tx_ready for 3 cycles
  always @(negedge clk) begin
    logic       obs_start;
    logic [7:0] obs_data;
    logic [7:0] exp_b;
    obs_start = tx_start8 | tx_start16;
    obs_data  = tx_start16 ? tx_data16 : tx_data8;
    if (obs_start) begin
      tx_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL tx_unexpected: got tx_data=%02h, required no tx_start", obs_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (obs_data !== exp_b)
          $display("FAIL tx_data: got %02h, required %02h", obs_data, exp_b);
        else
          n_pass++;
      end
      n_checks++;
      if (tx_ready !== 1'b1 || prev_start)
        $display("FAIL tx_handshake: tx_ready=%0b prev_start=%0b, required 1 and 0", tx_ready, prev_start);
      else
        n_pass++;
    end
    prev_start = obs_start;
    if (tx_auto) begin
      if (obs_start) begin
        tx_ready = 1'b0;
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300 && !(tx_cnt >= target && obs_busy == 1'b0); i++) @(negedge clk);
    n_checks++;
    if (tx_cnt < target || obs_busy !== 1'b0)
      $display("FAIL wait_done: tx_cnt=%0d busy=%0b, required tx_cnt>=%0d busy=0", tx_cnt, obs_busy, target);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_start8, tx_data8, alu_a8, alu_b8, alu_op8, busy8, frame_err8, overrun8} !== 36'h0)
      $display("FAIL reset8: got a=%02h b=%02h op=%b txd=%02h busy=%0b, required all 0",
               alu_a8, alu_b8, alu_op8, tx_data8, busy8);
    else n_pass++;
    n_checks++;
    if ({tx_start16, tx_data16, alu_a16, alu_b16, alu_op16, busy16, frame_err16, overrun16} !== 52'h0)
      $display("FAIL reset16: got a=%04h b=%04h op=%b txd=%02h busy=%0b, required all 0",
               alu_a16, alu_b16, alu_op16, tx_data16, busy16);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_add8();
    int t0;
    sel = 0; t0 = tx_cnt;
    exp_q.push_back(8'h08);
    send_byte(8'h05); send_byte(8'h2B); send_byte(8'h03);
    n_checks++;
    if (alu_a8 !== 8'h05 || alu_b8 !== 8'h03 || alu_op8 !== 6'b100000)
      $display("FAIL add8_operands: got a=%02h b=%02h op=%b, required 05 03 100000", alu_a8, alu_b8, alu_op8);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_start8 !== 1'b0) $display("FAIL add8_early_start: got %0b, required 0", tx_start8);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_start8 !== 1'b1) $display("FAIL add8_latency: got tx_start=%0b, required 1", tx_start8);
    else n_pass++;
    wait_done(t0 + 1);
    repeat (8) @(negedge clk);
    n_checks++;
    if (tx_cnt !== t0 + 1) $display("FAIL add8_count: got %0d tx_start, required 1", tx_cnt - t0);
    else n_pass++;
  endtask

  task automatic test_sub16();
    int t0;
    sel = 1; t0 = tx_cnt;
    exp_q.push_back(8'h33); exp_q.push_back(8'h12);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h2D); send_byte(8'h01); send_byte(8'h00);
    n_checks++;
    if (alu_a16 !== 16'h1234 || alu_b16 !== 16'h0001 || alu_op16 !== 6'b100010)
      $display("FAIL sub16_operands: got a=%04h b=%04h op=%b, required 1234 0001 100010", alu_a16, alu_b16, alu_op16);
    else n_pass++;
    wait_done(t0 + 2);
    repeat (8) @(negedge clk);
    n_checks++;
    if (tx_cnt !== t0 + 2) $display("FAIL sub16_count: got %0d tx_start, required 2", tx_cnt - t0);
    else n_pass++;
  endtask

  task automatic test_invalid_op();
    int t0;
    sel = 0; t0 = tx_cnt;
    exp_q.push_back(8'h3F);
    send_byte(8'h09); send_byte(8'h5A);
    n_checks++;
    if (frame_err8 !== 1'b1 || alu_a8 !== 8'h09)
      $display("FAIL invalid_err: got frame_err=%0b a=%02h, required 1 09", frame_err8, alu_a8);
    else n_pass++;
    wait_done(t0 + 1);
    exp_q.push_back(8'h02);
    send_byte(8'h02); send_byte(8'h26); send_byte(8'h03);
    wait_done(t0 + 2);
  endtask

  task automatic test_timeout();
    int t0, fe_cnt, fe_at;
    sel = 0; t0 = tx_cnt; fe_cnt = 0; fe_at = 0;
    send_byte(8'h05);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_err8) begin fe_cnt++; fe_at = k; end
    end
    n_checks++;
    if (fe_cnt != 1 || fe_at != 16)
      $display("FAIL timeout_pulse: got %0d pulses at idle cycle %0d, required 1 at 16", fe_cnt, fe_at);
    else n_pass++;
    n_checks++;
    if (tx_cnt != t0 || busy8 !== 1'b0 || alu_op8 !== 6'b100100)
      $display("FAIL timeout_state: got tx=%0d busy=%0b op=%b, required 0 0 100100", tx_cnt - t0, busy8, alu_op8);
    else n_pass++;
    exp_q.push_back(8'h02);
    send_byte(8'h01); send_byte(8'h2B); send_byte(8'h01);
    wait_done(t0 + 1);
  endtask

  task automatic test_overrun();
    int t0;
    sel = 0; t0 = tx_cnt;
    @(negedge clk);
    tx_auto = 1'b0; tx_ready = 1'b0;
    exp_q.push_back(8'h0A);
    send_byte(8'h07); send_byte(8'h2B); send_byte(8'h03);
    @(negedge clk);
    send_byte(8'hAA);
    n_checks++;
    if (overrun8 !== 1'b1 || alu_a8 !== 8'h07)
      $display("FAIL overrun_pulse: got overrun=%0b a=%02h, required 1 07", overrun8, alu_a8);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (overrun8 !== 1'b0) $display("FAIL overrun_width: got %0b, required 0", overrun8);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (tx_cnt != t0 || busy8 !== 1'b1)
      $display("FAIL overrun_hold: got tx=%0d busy=%0b, required 0 1", tx_cnt - t0, busy8);
    else n_pass++;
    tx_ready = 1'b1; tx_auto = 1'b1;
    wait_done(t0 + 1);
  endtask

  task automatic test_reset_mid();
    int t0;
    sel = 1;
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h2B); send_byte(8'h01);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_start16, tx_data16, alu_a16, alu_b16, alu_op16, busy16, frame_err16, overrun16} !== 52'h0)
      $display("FAIL reset_mid: got a=%04h b=%04h op=%b busy=%0b, required all 0", alu_a16, alu_b16, alu_op16, busy16);
    else n_pass++;
    reset = 1'b0;
    t0 = tx_cnt;
    exp_q.push_back(8'h15); exp_q.push_back(8'h00);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h2B); send_byte(8'h05); send_byte(8'h00);
    wait_done(t0 + 2);
    n_checks++;
    if (alu_a16 !== 16'h0010 || alu_b16 !== 16'h0005)
      $display("FAIL reset_mid_frame: got a=%04h b=%04h, required 0010 0005", alu_a16, alu_b16);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, op, e;
    int t0;
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      case (i % 3)
        0:       begin op = 8'h2B; e = a + b; end
        1:       begin op = 8'h5E; e = a ^ b; end
        default: begin op = 8'h7C; e = a | b; end
      endcase
      t0 = tx_cnt;
      exp_q.push_back(e);
      send_byte(a); send_byte(op); send_byte(b);
      wait_done(t0 + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add8();
    test_sub16();
    test_invalid_op();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending replies, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
